// File: rtl/tmds_rx_decoder.sv
// TMDS receive lane: finds the 10-bit symbol boundary from control-token runs,
// holds lock while tokens keep arriving, and decodes data/control symbols.
module tmds_rx_decoder #(
  parameter int unsigned p_lock_count   = 8,
  parameter int unsigned p_search_dwell = 1024,
  parameter int unsigned p_loss_timeout = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_symbol,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_valid,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int unsigned RUN_W   = $clog2(p_lock_count) + 1;
  localparam int unsigned DWELL_W = $clog2(p_search_dwell) + 1;
  localparam int unsigned LOSS_W  = $clog2(p_loss_timeout) + 1;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t              state, state_n;
  logic [RUN_W-1:0]    run_cnt, run_n;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_n;
  logic [LOSS_W-1:0]   loss_cnt, loss_n;
  logic [3:0]          offset_n;

  logic [9:0]  prev_word;
  logic [19:0] window_shifted;
  logic [9:0]  aligned;
  logic        tok_hit;
  logic [1:0]  tok_val;

  logic [9:0]  s1_sym;
  logic        s1_hit;
  logic [1:0]  s1_tok;

  logic [7:0]  t_byte;
  logic [7:0]  d_byte;
  logic        valid_d1;

  // Window holds the previous word in the low half, so bit 0 is the earliest bit.
  assign window_shifted = {i_symbol, prev_word} >> o_offset;
  assign aligned        = window_shifted[9:0];

  always_comb begin
    tok_hit = 1'b1;
    tok_val = 2'b00;
    case (aligned)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        tok_hit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_word <= '0;
      s1_sym    <= '0;
      s1_hit    <= 1'b0;
      s1_tok    <= '0;
    end else begin
      prev_word <= i_symbol;
      s1_sym    <= aligned;
      s1_hit    <= tok_hit;
      s1_tok    <= tok_val;
    end
  end

  always_comb begin
    t_byte    = s1_sym[9] ? ~s1_sym[7:0] : s1_sym[7:0];
    d_byte    = '0;
    d_byte[0] = t_byte[0];
    for (int unsigned i = 1; i < 8; i++) begin
      d_byte[i] = s1_sym[8] ? (t_byte[i] ^ t_byte[i-1]) : ~(t_byte[i] ^ t_byte[i-1]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
      o_ctrl <= '0;
      o_de   <= 1'b0;
    end else begin
      o_de   <= ~s1_hit;
      o_data <= s1_hit ? 8'h00 : d_byte;
      if (s1_hit) o_ctrl <= s1_tok;
    end
  end

  // Alignment FSM acts on the registered stage-1 hit; lock beats dwell expiry.
  always_comb begin
    state_n  = state;
    run_n    = run_cnt;
    dwell_n  = dwell_cnt;
    loss_n   = loss_cnt;
    offset_n = o_offset;
    case (state)
      SEARCH: begin
        if (s1_hit && (run_cnt >= RUN_W'(p_lock_count - 1))) begin
          state_n = LOCKED;
          run_n   = '0;
          dwell_n = '0;
          loss_n  = '0;
        end else if (dwell_cnt >= DWELL_W'(p_search_dwell - 1)) begin
          offset_n = (o_offset == 4'd9) ? 4'd0 : o_offset + 4'd1;
          run_n    = '0;
          dwell_n  = '0;
        end else begin
          if (!s1_hit)               run_n = '0;
          else if (run_cnt != '1)    run_n = run_cnt + 1'b1;
          if (dwell_cnt != '1)       dwell_n = dwell_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (s1_hit) begin
          loss_n = '0;
        end else if (loss_cnt >= LOSS_W'(p_loss_timeout - 1)) begin
          state_n  = SEARCH;
          offset_n = (o_offset == 4'd9) ? 4'd0 : o_offset + 4'd1;
          run_n    = '0;
          dwell_n  = '0;
          loss_n   = '0;
        end else if (loss_cnt != '1) begin
          loss_n = loss_cnt + 1'b1;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= SEARCH;
      run_cnt   <= '0;
      dwell_cnt <= '0;
      loss_cnt  <= '0;
      o_offset  <= '0;
      valid_d1  <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      state     <= state_n;
      run_cnt   <= run_n;
      dwell_cnt <= dwell_n;
      loss_cnt  <= loss_n;
      o_offset  <= offset_n;
      valid_d1  <= o_locked;
      o_valid   <= valid_d1;
    end
  end

  assign o_locked = (state == LOCKED);

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Self-checking bench for tmds_rx_decoder: bit-window reference model with a
// 2-cycle output scoreboard, plus directed lock/search/loss/reset scenarios.
module tb_tmds_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] i_symbol;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de, o_valid, o_locked;
  logic [3:0] o_offset;

  tmds_rx_decoder #(
    .p_lock_count  (8),
    .p_search_dwell(1024),
    .p_loss_timeout(4096)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_symbol(i_symbol),
    .o_data  (o_data),
    .o_ctrl  (o_ctrl),
    .o_de    (o_de),
    .o_valid (o_valid),
    .o_locked(o_locked),
    .o_offset(o_offset)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] TOK00 = 10'h354;
  localparam logic [9:0] TOK01 = 10'h0AB;
  localparam logic [9:0] TOK10 = 10'h154;
  localparam logic [9:0] TOK11 = 10'h2AB;

  typedef struct packed {
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [9:0] tok_tab [4];
  logic [9:0] prev_in;
  logic [3:0] m_off;
  logic [1:0] m_ctrl;
  exp_t       pend;
  bit         pend_valid;

  function automatic logic [9:0] align_model(input logic [9:0] prev, input logic [9:0] cur,
                                             input logic [3:0] off);
    logic [19:0] x;
    x = {cur, prev} >> off;
    return x[9:0];
  endfunction

  // Produces the input word that places symbol a at bit offset off.
  function automatic logic [9:0] enc(input logic [9:0] a, input logic [9:0] a_prev,
                                     input logic [3:0] off);
    logic [19:0] x;
    x = {a, a_prev} << off;
    return x[19:10];
  endfunction

  function automatic int tok_index(input logic [9:0] s);
    for (int k = 0; k < 4; k++) if (tok_tab[k] == s) return k;
    return -1;
  endfunction

  function automatic logic [7:0] data_model(input logic [9:0] s);
    logic [7:0] t, d;
    t    = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = t[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (t[i] ^ t[i-1]) : !(t[i] ^ t[i-1]);
    return d;
  endfunction

  task automatic model_reset();
    prev_in    = '0;
    m_off      = '0;
    m_ctrl     = '0;
    pend_valid = 1'b0;
  endtask

  task automatic step(input logic [9:0] w, input bit chk);
    exp_t       e;
    logic [9:0] s;
    int         ti;
    s  = align_model(prev_in, w, m_off);
    ti = tok_index(s);
    if (ti >= 0) begin
      m_ctrl = 2'(ti);
      e.de   = 1'b0;
      e.data = 8'h00;
    end else begin
      e.de   = 1'b1;
      e.data = data_model(s);
    end
    e.ctrl   = m_ctrl;
    i_symbol = w;
    @(posedge clk);
    #1;
    if (chk && pend_valid) begin
      n_checks++;
      if (o_de !== pend.de || o_data !== pend.data || o_ctrl !== pend.ctrl) begin
        n_fail++;
        $display("FAIL pipe_out: got de=%0b data=%02h ctrl=%0d, expected de=%0b data=%02h ctrl=%0d",
                 o_de, o_data, o_ctrl, pend.de, pend.data, pend.ctrl);
      end
    end
    pend       = e;
    pend_valid = 1'b1;
    prev_in    = w;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    i_symbol = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_locked(input string name, input logic exp_l, input logic exp_v);
    n_checks++;
    if (o_locked !== exp_l || o_valid !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got locked=%0b valid=%0b, expected locked=%0b valid=%0b",
               name, o_locked, o_valid, exp_l, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    i_symbol = 10'h3FF;
    #1;
    n_checks++;
    if (o_data !== 8'h00 || o_ctrl !== 2'b00 || o_de !== 1'b0 || o_valid !== 1'b0 ||
        o_locked !== 1'b0 || o_offset !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%02h ctrl=%0d de=%0b valid=%0b locked=%0b off=%0d, expected all 0",
               o_data, o_ctrl, o_de, o_valid, o_locked, o_offset);
    end
    do_reset();
  endtask

  // Offset 0 means the aligned symbol is the previous word, so the first token
  // reaches stage 1 at edge 2, the 8th at edge 9, and lock appears at edge 10.
  task automatic test_aligned_lock();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(TOK00, 1'b1);
      check_locked("aligned_lock", (i >= 10), (i >= 12));
    end
    n_checks++;
    if (o_offset !== 4'd0) begin
      n_fail++;
      $display("FAIL aligned_offset: got %0d, expected 0", o_offset);
    end
    step(10'h100, 1'b1);
    step(TOK00, 1'b1);
    step(TOK00, 1'b1);
  endtask

  task automatic test_data_decode();
    step(10'h2FF, 1'b1);
    step(TOK00, 1'b1);
    step(TOK00, 1'b1);
    n_checks++;
    if (o_data !== 8'hFE || o_de !== 1'b1) begin
      n_fail++;
      $display("FAIL decode_2ff: got data=%02h de=%0b, expected data=fe de=1", o_data, o_de);
    end
    step(TOK11, 1'b1);
    step(10'h100, 1'b1);
    step(TOK00, 1'b1);
    n_checks++;
    if (o_ctrl !== 2'b11 || o_de !== 1'b0 || o_data !== 8'h00) begin
      n_fail++;
      $display("FAIL decode_tok11: got ctrl=%0d de=%0b data=%02h, expected ctrl=3 de=0 data=00",
               o_ctrl, o_de, o_data);
    end
    step(TOK00, 1'b1);
    step(TOK00, 1'b1);
  endtask

  task automatic test_random_locked(input int unsigned n);
    logic [9:0] a, a_prev;
    a_prev = TOK00;
    for (int unsigned i = 0; i < n; i++) begin
      if (i == n - 1 || $urandom_range(0, 3) == 0) a = tok_tab[$urandom_range(0, 3)];
      else                                         a = 10'($urandom);
      step(enc(a, a_prev, m_off), 1'b1);
      check_locked("random_locked", 1'b1, 1'b1);
      a_prev = a;
    end
  endtask

  task automatic test_loss();
    logic [9:0] a;
    for (int i = 1; i <= 4101; i++) begin
      do a = 10'($urandom); while (tok_index(a) >= 0);
      step(a, (i <= 4097));
      if (i == 4097) check_locked("loss_before", 1'b1, 1'b1);
      if (i == 4098) begin
        check_locked("loss_drop", 1'b0, 1'b1);
        n_checks++;
        if (o_offset !== 4'd1) begin
          n_fail++;
          $display("FAIL loss_offset: got %0d, expected 1", o_offset);
        end
      end
      if (i == 4099) check_locked("loss_valid_hold", 1'b0, 1'b1);
      if (i == 4100) check_locked("loss_valid_drop", 1'b0, 1'b0);
    end
  endtask

  task automatic test_search();
    logic [9:0] r;
    int         lock_at;
    do_reset();
    m_off   = 4'd3;
    r       = enc(TOK01, TOK01, 4'd3);
    lock_at = 0;
    for (int i = 1; i <= 3 * 1024 + 10; i++) begin
      step(r, 1'b0);
      if (i == 1023 || i == 1024 || i == 2048 || i == 3072) begin
        n_checks++;
        if (o_offset !== 4'((i - 1 + 1) / 1024)) begin
          n_fail++;
          $display("FAIL search_offset@%0d: got %0d, expected %0d", i, o_offset, (i / 1024));
        end
      end
      if (o_locked === 1'b1) begin
        lock_at = i;
        break;
      end
    end
    n_checks++;
    if (lock_at <= 3072 || o_offset !== 4'd3) begin
      n_fail++;
      $display("FAIL search_lock: got lock_cycle=%0d offset=%0d, expected lock in (3072,3082] at offset 3",
               lock_at, o_offset);
    end
    pend_valid = 1'b0;
    repeat (4) step(r, 1'b1);
    n_checks++;
    if (o_ctrl !== 2'b01 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL search_ctrl: got ctrl=%0d valid=%0b, expected ctrl=1 valid=1", o_ctrl, o_valid);
    end
  endtask

  task automatic test_interrupted();
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      if (i <= 7 || (i >= 9 && i <= 16)) step(TOK00, 1'b1);
      else                               step(10'h100, 1'b1);
      if (i <= 20) check_locked("interrupted_run", (i >= 18), (i >= 20));
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] r;
    int         lock_at;
    do_reset();
    m_off   = 4'd5;
    r       = enc(TOK10, TOK10, 4'd5);
    lock_at = 0;
    for (int i = 1; i <= 5 * 1024 + 20; i++) begin
      step(r, 1'b0);
      if (o_locked === 1'b1) begin
        lock_at = i;
        break;
      end
    end
    n_checks++;
    if (lock_at == 0 || o_offset !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_prelock: got lock_cycle=%0d offset=%0d, expected lock at offset 5", lock_at, o_offset);
    end
    repeat (4) step(r, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_data !== 8'h00 || o_ctrl !== 2'b00 || o_de !== 1'b0 || o_valid !== 1'b0 ||
        o_locked !== 1'b0 || o_offset !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got data=%02h ctrl=%0d de=%0b valid=%0b locked=%0b off=%0d, expected all 0",
               o_data, o_ctrl, o_de, o_valid, o_locked, o_offset);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 12; i++) begin
      step(TOK00, 1'b1);
      check_locked("mid_relock", (i >= 10), (i >= 12));
    end
  endtask

  initial begin
    tok_tab[0] = TOK00;
    tok_tab[1] = TOK01;
    tok_tab[2] = TOK10;
    tok_tab[3] = TOK11;
    model_reset();
    test_reset();
    test_aligned_lock();
    test_data_decode();
    test_random_locked(200);
    test_loss();
    test_search();
    test_random_locked(200);
    test_interrupted();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
